// File: rtl/glb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glb_arb_pkg
// Description : Shared types and constants for the GLB port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package glb_arb_pkg;

  // Per-port burst FSM state
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int BEAT_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int LEN_W_DEF  = 8;

  // Index width for an N-entry requester set (never zero)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/glb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Selects the first asserted
//               request at or after ptr, searching cyclically. The pointer
//               register is owned by the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import glb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    idx    = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, ptr} + (IW + 1)'(k);
      if (w_sum >= (IW + 1)'(N)) begin
        w_sum = w_sum - (IW + 1)'(N);
      end
      w_cand = w_sum[IW-1:0];
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
    any = |req;
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/glb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : glb_arbiter
// Description : Shares the single-read / single-write GLB ports between
//               multiple burst requesters with independent round-robin
//               arbitration on each side. A grant owns its port for len+1
//               32-bit beats at an auto-incrementing byte address.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_arbiter
  import glb_arb_pkg::*;
#(
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_RD*LEN_W-1:0]      rd_len,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic [NUM_RD-1:0]            rd_rvalid,
  output logic                         rd_rlast,
  output logic [DATA_W-1:0]            rd_rdata,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*LEN_W-1:0]      wr_len,
  output logic [NUM_WR-1:0]            wr_gnt,
  input  logic [NUM_WR-1:0]            wr_dvalid,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  output logic [NUM_WR-1:0]            wr_dready,
  output logic                         glb_re,
  output logic [ADDR_WIDTH-1:0]        glb_raddr,
  input  logic [DATA_W-1:0]            glb_dout,
  output logic                         glb_we,
  output logic [ADDR_WIDTH-1:0]        glb_waddr,
  output logic [DATA_W-1:0]            glb_din
);

  localparam int RIW = idx_width(NUM_RD);
  localparam int WIW = idx_width(NUM_WR);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(BEAT_BYTES);

  // ---------------------------------------------------------------- unpack
  logic [ADDR_WIDTH-1:0] w_rd_addr_arr [NUM_RD];
  logic [LEN_W-1:0]      w_rd_len_arr  [NUM_RD];
  logic [ADDR_WIDTH-1:0] w_wr_addr_arr [NUM_WR];
  logic [LEN_W-1:0]      w_wr_len_arr  [NUM_WR];
  logic [DATA_W-1:0]     w_wr_data_arr [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign w_rd_addr_arr[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd_len_arr[i]  = rd_len[i*LEN_W +: LEN_W];
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign w_wr_addr_arr[i] = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_len_arr[i]  = wr_len[i*LEN_W +: LEN_W];
    assign w_wr_data_arr[i] = wr_data[i*DATA_W +: DATA_W];
  end

  // ================================================================ read side
  state_t                r_rd_state, w_rd_state_nxt;
  logic [RIW-1:0]        r_rd_ptr, r_rd_id;
  logic [ADDR_WIDTH-1:0] r_rd_base;
  logic [LEN_W-1:0]      r_rd_len, r_rd_beat;
  logic                  r_rd_hold;      // forces the idle cycle between bursts
  logic                  w_rd_take, w_rd_last;
  logic [NUM_RD-1:0]     w_rd_arb_gnt;
  logic [RIW-1:0]        w_rd_arb_idx;
  logic                  w_rd_arb_any;
  logic                  r_rv, r_rlast;
  logic [RIW-1:0]        r_rid;

  rr_arbiter #(.N(NUM_RD), .IW(RIW)) u_rd_arb (
    .req (rd_req),
    .ptr (r_rd_ptr),
    .gnt (w_rd_arb_gnt),
    .idx (w_rd_arb_idx),
    .any (w_rd_arb_any)
  );

  // Read FSM next state and GLB read-port drive
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_take      = 1'b0;
    w_rd_last      = 1'b0;
    glb_re         = 1'b0;
    glb_raddr      = '0;
    case (r_rd_state)
      IDLE: begin
        if (w_rd_arb_any && !r_rd_hold && !rst) begin
          w_rd_take      = 1'b1;
          w_rd_state_nxt = BURST;
        end
      end
      BURST: begin
        glb_re    = 1'b1;
        glb_raddr = r_rd_base + ADDR_WIDTH'(r_rd_beat) * BEAT_INC;
        w_rd_last = (r_rd_beat == r_rd_len);
        if (w_rd_last) begin
          w_rd_state_nxt = IDLE;
        end
      end
      default: w_rd_state_nxt = IDLE;
    endcase
  end

  assign rd_gnt = w_rd_take ? w_rd_arb_gnt : '0;

  // Read FSM state, burst context and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= IDLE;
      r_rd_ptr   <= '0;
      r_rd_id    <= '0;
      r_rd_base  <= '0;
      r_rd_len   <= '0;
      r_rd_beat  <= '0;
      r_rd_hold  <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_hold  <= 1'b0;
      if (w_rd_take) begin
        r_rd_base <= w_rd_addr_arr[w_rd_arb_idx];
        r_rd_len  <= w_rd_len_arr[w_rd_arb_idx];
        r_rd_id   <= w_rd_arb_idx;
        r_rd_beat <= '0;
        r_rd_ptr  <= (w_rd_arb_idx == RIW'(NUM_RD - 1)) ? '0 : w_rd_arb_idx + 1'b1;
      end else if (r_rd_state == BURST) begin
        if (w_rd_last) begin
          r_rd_beat <= '0;
          r_rd_hold <= 1'b1;
        end else begin
          r_rd_beat <= r_rd_beat + 1'b1;
        end
      end
    end
  end

  // Align owner id and last flag with the GLB's one-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rv    <= 1'b0;
      r_rid   <= '0;
      r_rlast <= 1'b0;
    end else begin
      r_rv    <= glb_re;
      r_rid   <= r_rd_id;
      r_rlast <= w_rd_last;
    end
  end

  assign rd_rvalid = r_rv ? (NUM_RD'(1) << r_rid) : '0;
  assign rd_rlast  = r_rv & r_rlast;
  assign rd_rdata  = r_rv ? glb_dout : '0;

  // =============================================================== write side
  state_t                r_wr_state, w_wr_state_nxt;
  logic [WIW-1:0]        r_wr_ptr, r_wr_id;
  logic [ADDR_WIDTH-1:0] r_wr_base;
  logic [LEN_W-1:0]      r_wr_len, r_wr_beat;
  logic                  r_wr_hold;
  logic                  w_wr_take, w_wr_acc, w_wr_last;
  logic [NUM_WR-1:0]     w_wr_arb_gnt;
  logic [WIW-1:0]        w_wr_arb_idx;
  logic                  w_wr_arb_any;

  rr_arbiter #(.N(NUM_WR), .IW(WIW)) u_wr_arb (
    .req (wr_req),
    .ptr (r_wr_ptr),
    .gnt (w_wr_arb_gnt),
    .idx (w_wr_arb_idx),
    .any (w_wr_arb_any)
  );

  // Write FSM next state; beats pass straight through to the GLB on accept
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_take      = 1'b0;
    w_wr_acc       = 1'b0;
    w_wr_last      = 1'b0;
    wr_dready      = '0;
    glb_we         = 1'b0;
    glb_waddr      = '0;
    glb_din        = '0;
    case (r_wr_state)
      IDLE: begin
        if (w_wr_arb_any && !r_wr_hold && !rst) begin
          w_wr_take      = 1'b1;
          w_wr_state_nxt = BURST;
        end
      end
      BURST: begin
        wr_dready = NUM_WR'(1) << r_wr_id;
        w_wr_acc  = wr_dvalid[r_wr_id];
        if (w_wr_acc) begin
          glb_we    = 1'b1;
          glb_waddr = r_wr_base + ADDR_WIDTH'(r_wr_beat) * BEAT_INC;
          glb_din   = w_wr_data_arr[r_wr_id];
          w_wr_last = (r_wr_beat == r_wr_len);
          if (w_wr_last) begin
            w_wr_state_nxt = IDLE;
          end
        end
      end
      default: w_wr_state_nxt = IDLE;
    endcase
  end

  assign wr_gnt = w_wr_take ? w_wr_arb_gnt : '0;

  // Write FSM state, burst context and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= IDLE;
      r_wr_ptr   <= '0;
      r_wr_id    <= '0;
      r_wr_base  <= '0;
      r_wr_len   <= '0;
      r_wr_beat  <= '0;
      r_wr_hold  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_hold  <= 1'b0;
      if (w_wr_take) begin
        r_wr_base <= w_wr_addr_arr[w_wr_arb_idx];
        r_wr_len  <= w_wr_len_arr[w_wr_arb_idx];
        r_wr_id   <= w_wr_arb_idx;
        r_wr_beat <= '0;
        r_wr_ptr  <= (w_wr_arb_idx == WIW'(NUM_WR - 1)) ? '0 : w_wr_arb_idx + 1'b1;
      end else if (w_wr_acc) begin
        if (w_wr_last) begin
          r_wr_beat <= '0;
          r_wr_hold <= 1'b1;
        end else begin
          r_wr_beat <= r_wr_beat + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_glb_arbiter
// Description : Directed self-checking bench for glb_arbiter with a
//               write-first GLB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_arbiter;

  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int AW     = 32;
  localparam int LW     = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_RD-1:0]     rd_req;
  logic [NUM_RD*AW-1:0]  rd_addr;
  logic [NUM_RD*LW-1:0]  rd_len;
  logic [NUM_RD-1:0]     rd_gnt, rd_rvalid;
  logic                  rd_rlast;
  logic [31:0]           rd_rdata;
  logic [NUM_WR-1:0]     wr_req;
  logic [NUM_WR*AW-1:0]  wr_addr;
  logic [NUM_WR*LW-1:0]  wr_len;
  logic [NUM_WR-1:0]     wr_gnt, wr_dvalid, wr_dready;
  logic [NUM_WR*32-1:0]  wr_data;
  logic                  glb_re, glb_we;
  logic [AW-1:0]         glb_raddr, glb_waddr;
  logic [31:0]           glb_dout = 32'h0;
  logic [31:0]           glb_din;

  // backdoor preload port into the GLB model
  logic                  bd_we;
  logic [31:0]           bd_addr, bd_data;
  logic [31:0]           mem [0:1023];

  int                    n_checks = 0;
  int                    n_pass   = 0;
  logic [31:0]           exp_q [$];

  always #5 clk = ~clk;

  glb_arbiter #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ADDR_WIDTH(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rlast(rd_rlast), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_dvalid(wr_dvalid), .wr_data(wr_data), .wr_dready(wr_dready),
    .glb_re(glb_re), .glb_raddr(glb_raddr), .glb_dout(glb_dout),
    .glb_we(glb_we), .glb_waddr(glb_waddr), .glb_din(glb_din)
  );

  // GLB model: one-cycle read latency, write-first on same-address collision
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr[11:2]] <= bd_data;
    else if (glb_we) mem[glb_waddr[11:2]] <= glb_din;
    if (glb_re)
      glb_dout <= (glb_we && glb_waddr == glb_raddr) ? glb_din : mem[glb_raddr[11:2]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  // One read burst from requester id; checks grant, address and response timing
  task automatic run_read(input int id, input logic [31:0] addr, input int len);
    logic [31:0] ea;
    rd_addr[id*AW +: AW] = addr;
    rd_len[id*LW +: LW]  = LW'(len);
    rd_req[id]           = 1'b1;
    #1;
    chk("rd_gnt", rd_gnt, 64'(1 << id));
    tick();
    rd_req[id] = 1'b0;
    for (int c = 1; c <= len + 2; c++) begin
      #1;
      chk("rd_re", glb_re, (c <= len + 1));
      if (c <= len + 1) begin
        ea = addr + 32'(4 * (c - 1));
        chk("rd_raddr", glb_raddr, ea);
      end
      chk("rd_rvalid", rd_rvalid, (c >= 2) ? 64'(1 << id) : 64'h0);
      if (c >= 2) begin
        chk("rd_rdata", rd_rdata, exp_q[c-2]);
        chk("rd_rlast", rd_rlast, (c == len + 2));
      end
      tick();
    end
    #1;
    chk("rd_rvalid_end", rd_rvalid, 0);
    tick();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] g_val [$];
    int         g_cyc [$];
    logic [4:0] pat;
    logic [31:0] dat [5];
    int         bad;

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    rd_req = '0; rd_addr = '0; rd_len = '0;
    wr_req = '0; wr_addr = '0; wr_len = '0; wr_dvalid = '0; wr_data = '0;

    preload(32'h100, 32'hA0);
    preload(32'h104, 32'hA1);
    preload(32'h108, 32'hA2);
    preload(32'h10C, 32'hA3);
    preload(32'hFFFFFFFC, 32'h55);
    preload(32'h0, 32'h66);
    preload(32'h300, 32'h12345678);

    // ---- reset state, with requests asserted
    rd_req = '1; wr_req = '1;
    #1;
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rvalid", rd_rvalid, 0);
    chk("rst_re_we", {glb_re, glb_we}, 0);
    chk("rst_dready", wr_dready, 0);
    chk("rst_addr", {glb_raddr, glb_waddr}, 0);
    rd_req = '0; wr_req = '0;
    tick();
    rst = 1'b0;
    tick();

    // ---- round robin, len 0, all requesting continuously
    rd_req = '1;
    for (int c = 0; c < 40 && g_val.size() < 5; c++) begin
      #1;
      if (rd_gnt != 0) begin
        g_val.push_back(rd_gnt);
        g_cyc.push_back(c);
      end
      tick();
      if (g_val.size() == 5) rd_req = '0;
    end
    rd_req = '0;
    chk("rr_count", g_val.size(), 5);
    for (int g = 0; g < g_val.size(); g++) chk("rr_order", g_val[g], 64'(1 << (g % 4)));
    for (int g = 1; g < g_cyc.size(); g++) chk("rr_gap", g_cyc[g] - g_cyc[g-1], 3);
    repeat (4) tick();

    // ---- single read
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_read(2, 32'h100, 3);

    // ---- write with dvalid stalls
    wr_addr[AW +: AW] = 32'h200;
    wr_len[LW +: LW]  = 8'd1;
    wr_req            = 2'b10;
    #1;
    chk("wr_gnt", wr_gnt, 2'b10);
    tick();
    wr_req = '0;
    pat = 5'b01001;
    dat = '{32'h11, 32'hBAD0, 32'hBAD1, 32'h22, 32'hBAD2};
    for (int c = 0; c < 5; c++) begin
      wr_dvalid[1]     = pat[c];
      wr_data[32 +: 32] = dat[c];
      #1;
      chk("wr_we", glb_we, pat[c]);
      chk("wr_dready", wr_dready, (c < 4) ? 2'b10 : 2'b00);
      if (pat[c]) begin
        chk("wr_waddr", glb_waddr, (c == 0) ? 32'h200 : 32'h204);
        chk("wr_din", glb_din, dat[c]);
      end
      tick();
    end
    wr_dvalid = '0;
    tick();
    exp_q = '{32'h11, 32'h22};
    run_read(0, 32'h200, 1);

    // ---- concurrent read and write on the same address
    rd_addr[0 +: AW] = 32'h300; rd_len[0 +: LW] = 8'd0; rd_req = 4'b0001;
    wr_addr[0 +: AW] = 32'h300; wr_len[0 +: LW] = 8'd0; wr_req = 2'b01;
    #1;
    chk("cc_gnt", {rd_gnt, wr_gnt}, {4'b0001, 2'b01});
    tick();
    rd_req = '0; wr_req = '0;
    wr_dvalid = 2'b01; wr_data[0 +: 32] = 32'hDEADBEEF;
    #1;
    chk("cc_ports", {glb_re, glb_we, glb_raddr, glb_waddr}, {2'b11, 32'h300, 32'h300});
    tick();
    wr_dvalid = '0;
    #1;
    chk("cc_rvalid", rd_rvalid, 4'b0001);
    chk("cc_rdata", rd_rdata, 32'hDEADBEEF);
    repeat (3) tick();

    // ---- address wrap
    exp_q = '{32'h55, 32'h66};
    run_read(3, 32'hFFFFFFFC, 1);

    // ---- reset in the middle of a len-7 read
    rd_addr[AW +: AW] = 32'h400; rd_len[LW +: LW] = 8'd7; rd_req = 4'b0010;
    #1;
    chk("mr_gnt", rd_gnt, 4'b0010);
    tick();
    rd_req = '0;
    tick();
    tick();
    #1;
    chk("mr_pre_raddr", glb_raddr, 32'h408);
    chk("mr_pre_rvalid", rd_rvalid, 4'b0010);
    rst = 1'b1;
    #1;
    chk("mr_outs", {rd_gnt, rd_rvalid, rd_rlast, rd_rdata, glb_re, glb_raddr}, 0);
    chk("mr_wouts", {wr_gnt, wr_dready, glb_we, glb_waddr, glb_din}, 0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rd_rvalid != 0 || glb_re) bad++;
      tick();
    end
    chk("mr_quiet", bad, 0);
    rd_req = '1;
    #1;
    chk("mr_ptr0", rd_gnt, 4'b0001);
    tick();
    rd_req = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/glb_arbiter.md
Name: glb_arbiter

Overview:
- Shares the single-read-port / single-write-port global buffer (GLB) between multiple on-chip requesters (DMA, PE-array feeders, output writers).
- Independent round-robin arbitration on the read side and the write side.
- Each grant owns the port for a burst of 32-bit beats with auto-incrementing byte address.
- Sits between the requester fabric and the GLB macro; drives the GLB re/r_addr/we/w_addr/din pins and consumes dout.

Parameters:
- NUM_RD, 4, number of read requesters
- NUM_WR, 2, number of write requesters
- ADDR_WIDTH, 32, GLB byte-address width
- LEN_W, 8, burst-length field width; beats = len+1 (1..256)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_req  in  NUM_RD  read burst request, held until rd_gnt
- rd_addr  in  NUM_RD*ADDR_WIDTH  per-requester base byte address (slice i)
- rd_len  in  NUM_RD*LEN_W  per-requester beats-1
- rd_gnt  out  NUM_RD  one-cycle grant pulse, one-hot
- rd_rvalid  out  NUM_RD  read data valid, one-hot to burst owner
- rd_rlast  out  1  final beat of current read burst (qualified by rd_rvalid)
- rd_rdata  out  32  read data, shared by all read requesters
- wr_req  in  NUM_WR  write burst request, held until wr_gnt
- wr_addr  in  NUM_WR*ADDR_WIDTH  per-requester base byte address
- wr_len  in  NUM_WR*LEN_W  per-requester beats-1
- wr_gnt  out  NUM_WR  one-cycle grant pulse, one-hot
- wr_dvalid  in  NUM_WR  write beat valid
- wr_data  in  NUM_WR*32  write beat data
- wr_dready  out  NUM_WR  beat-accept ready, high only for owner during write burst
- glb_re  out  1  GLB read enable
- glb_raddr  out  ADDR_WIDTH  GLB read byte address
- glb_dout  in  32  GLB read data, valid one cycle after glb_re
- glb_we  out  1  GLB write enable
- glb_waddr  out  ADDR_WIDTH  GLB write byte address
- glb_din  out  32  GLB write data

Behaviour:
- Reset: all outputs 0; both FSMs IDLE; both round-robin pointers 0; beat counters 0. Reset mid-burst aborts it; no rd_rvalid or glb_we after reset deasserts until a new grant.
- Read FSM, states IDLE and RD_BURST.
  - IDLE: if any rd_req, rr_arbiter picks the first requester at or after the pointer (cyclic). Cycle T: rd_gnt[i]=1; latch base, len, id; go to RD_BURST; pointer := (i+1) mod NUM_RD.
  - RD_BURST, cycles T+1..T+L+1 (L=len): glb_re=1, glb_raddr=base+4*beat; beat++. At beat==len, return to IDLE.
  - Response: rd_rvalid[id]=1 and rd_rdata=glb_dout at T+2..T+L+2 (one-cycle registered pipeline of re/id/last); rd_rlast on the final beat.
  - Minimum one bubble cycle between bursts: the next grant is never earlier than T+L+2.
- Write FSM, states IDLE and WR_BURST; arbitration, grant and pointer rules identical to read.
  - WR_BURST: wr_dready[id]=1. A beat is accepted in the cycle wr_dvalid[id]&&wr_dready[id]; in that cycle, combinationally, glb_we=1, glb_waddr=base+4*beat, glb_din=wr_data slice id.
  - Beat counter advances only on acceptance; dvalid gaps stall indefinitely.
  - Last accepted beat: dready drops next cycle; return to IDLE.
- Requests: rd_req/wr_req are ignored while the corresponding FSM is busy. Deasserting a request after grant has no effect on the granted burst.
- Arithmetic:
  - Address increment modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Unaligned bases are permitted; low bits pass through unchanged.
  - Beat counter is LEN_W bits, compared to the latched len.
- Simultaneous read and write bursts run fully in parallel. Same-address same-cycle access relies on the GLB's write-first behaviour (read returns new data); the arbiter adds no interlock.
- Idle GLB outputs: glb_re=0, glb_we=0; addresses and din 0.

Decomposition:
- Package glb_arb_pkg: state enum (IDLE, BURST), BEAT_BYTES=4, DATA_W=32, LEN_W default.
- Sub-module rr_arbiter #(N): inputs req, ptr, output one-hot gnt, index, any. Purely combinational; pointer register lives in the parent. Instantiated once for read and once for write.

Test Plan:
- Single read: rd_req[2], addr 0x100, len 3, GLB preloaded 0xA0..0xA3 -> rd_gnt[2] at T; glb_raddr 0x100,0x104,0x108,0x10C at T+1..T+4; rd_rvalid[2] with rdata 0xA0..0xA3 at T+2..T+5; rlast at T+5.
- Round-robin: rd_req=4'b1111 held continuously, len 0 each -> grant order 0,1,2,3,0; each grant exactly 3 cycles after the previous.
- Write with stalls: wr_req[1], addr 0x200, len 1, dvalid pattern 1,0,0,1, data 0x11 then 0x22 -> glb_we only in cycles 1 and 4; waddr 0x200 then 0x204; readback 0x11, 0x22.
- Concurrent same address: write burst to 0x300 (data 0xDEADBEEF) aligned in the same cycle as a read beat at 0x300 -> rd_rdata=0xDEADBEEF one cycle later.
- Wrap: rd_addr 0xFFFFFFFC, len 1 -> glb_raddr 0xFFFFFFFC then 0x00000000.
- Reset mid-burst: assert rst during beat 2 of a len-7 read -> all outputs 0 immediately; no rd_rvalid afterwards; next request granted to pointer 0 first.
